// File: rtl/m65c02_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m65c02_add_pkg
//  Description : Shared definitions for the parametrised M65C02 binary/BCD
//                adder: sequencer states, decimal adjust constants, the
//                largest legal BCD digit and the Op encodings.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package m65c02_add_pkg;

    // Sequencer states: IDLE waits for a start, DEC walks the digits,
    // DONE presents the one-cycle Val pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decimal correction added to a binary nibble sum.
    localparam logic [3:0] ADJ_ADD   = 4'h6;
    localparam logic [3:0] ADJ_SUB   = 4'hA;

    // Largest valid BCD digit.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Op input encodings.
    localparam logic       OP_ADD    = 1'b0;
    localparam logic       OP_SUB    = 1'b1;

endpackage : m65c02_add_pkg
`default_nettype wire

// File: rtl/m65c02_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : m65c02_bcd_digit
//  Description : Combinational single-nibble BCD add/subtract cell. The
//                right operand arrives already inverted for subtraction, so
//                the cell only has to apply the decimal correction.
//  Ports       : q      in  4  left digit
//                m      in  4  right digit (inverted for subtract)
//                c_in   in  1  digit carry in (subtract: 1 = no borrow)
//                op     in  1  0 = add, 1 = subtract
//                digit  out 4  corrected result digit
//                c_out  out 1  digit carry out (subtract: 1 = no borrow)
//  Revision    : 1.0  initial release
// ============================================================================
module m65c02_bcd_digit (
    input  logic [3:0] q,
    input  logic [3:0] m,
    input  logic       c_in,
    input  logic       op,
    output logic [3:0] digit,
    output logic       c_out
);
    import m65c02_add_pkg::*;

    logic [4:0] w_t;

    always_comb begin
        w_t   = {1'b0, q} + {1'b0, m} + {4'b0000, c_in};
        digit = w_t[3:0];
        c_out = 1'b0;
        if (op == OP_ADD) begin
            // Decimal carry whenever the binary sum passes 9.
            if (w_t > {1'b0, DIGIT_MAX}) begin
                digit = w_t[3:0] + ADJ_ADD;
                c_out = 1'b1;
            end
        end else begin
            // With ~R as operand, no binary carry means a borrow occurred;
            // adding 0xA (i.e. subtracting 6 mod 16) restores a BCD digit.
            if (w_t[4]) begin
                c_out = 1'b1;
            end else begin
                digit = w_t[3:0] + ADJ_SUB;
            end
        end
    end

endmodule : m65c02_bcd_digit
`default_nettype wire

// File: rtl/m65c02_add_n.sv
`default_nettype none
// ============================================================================
//  Module      : m65c02_add_n
//  Description : Parametrised binary/decimal adder for the M65C02A ALU.
//                Binary add/subtract finishes in one registered cycle.
//                Decimal add/subtract is processed one BCD digit per clock,
//                least significant digit first, through a single shared
//                nibble cell. One operation in flight; Rdy/Val handshake.
//  Ports       : Clk    in  1    system clock (rising edge)
//                Rst    in  1    asynchronous active-high reset
//                En_AU  in  1    start binary operation
//                En_DU  in  1    start decimal operation
//                Op     in  1    0 = add, 1 = subtract
//                Q      in  W    left operand
//                R      in  W    right operand
//                Ci     in  1    carry in (subtract: 1 = no borrow)
//                Abort  in  1    cancel an in-flight decimal operation
//                Rdy    out 1    idle or in Val cycle; start accepted
//                Out    out W+1  {carry-out, result}
//                OV     out 1    two's-complement overflow
//                Val    out 1    one-cycle result-valid pulse
//  Revision    : 1.0  initial release
// ============================================================================
module m65c02_add_n #(
    parameter int DIGITS = 4,   // number of BCD digits, W = 4*DIGITS (2..8)
    parameter int CW     = 3    // digit counter width, 2**CW > DIGITS
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En_AU,
    input  logic                En_DU,
    input  logic                Op,
    input  logic [4*DIGITS-1:0] Q,
    input  logic [4*DIGITS-1:0] R,
    input  logic                Ci,
    input  logic                Abort,
    output logic                Rdy,
    output logic [4*DIGITS:0]   Out,
    output logic                OV,
    output logic                Val
);
    import m65c02_add_pkg::*;

    localparam int          c_width = 4 * DIGITS;
    localparam logic [CW-1:0] c_last = CW'(DIGITS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;

    // r_q is both the left-operand shifter and the result shifter: each
    // step consumes its low nibble and inserts the result digit at the top,
    // so after DIGITS steps it holds the complete result in order.
    logic [c_width-1:0]    r_q;
    logic [c_width-1:0]    r_m;
    logic                  r_op;
    logic                  r_c;
    logic [CW-1:0]         r_cnt;
    logic                  r_ov_pend;
    logic [c_width:0]      r_out;
    logic                  r_ov;

    // ------------------------------------------------------------------
    // Start-edge arithmetic (binary result and overflow)
    // ------------------------------------------------------------------
    logic [c_width-1:0]    w_m_in;
    logic [c_width:0]      w_bin;
    logic                  w_ov;

    assign w_m_in = (Op == OP_SUB) ? ~R : R;
    assign w_bin  = {1'b0, Q} + {1'b0, w_m_in} + {{c_width{1'b0}}, Ci};
    // Carry into MSB xor carry out equals "operands agree in sign but the
    // sum sign differs"; the sign form avoids a second partial adder.
    assign w_ov   = (Q[c_width-1] == w_m_in[c_width-1]) &&
                    (w_bin[c_width-1] != Q[c_width-1]);

    // ------------------------------------------------------------------
    // Shared digit cell, fed by the low nibbles of the operand shifters
    // ------------------------------------------------------------------
    logic [3:0]            w_digit;
    logic                  w_dc;
    logic [c_width-1:0]    w_q_nxt;

    m65c02_bcd_digit u_digit (
        .q     (r_q[3:0]),
        .m     (r_m[3:0]),
        .c_in  (r_c),
        .op    (r_op),
        .digit (w_digit),
        .c_out (w_dc)
    );

    assign w_q_nxt = {w_digit, r_q[c_width-1:4]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic w_start;
    logic w_go_bin;
    logic w_go_dec;
    logic w_step;
    logic w_last;

    assign w_start = En_AU ^ En_DU;

    always_comb begin
        w_state_nxt = r_state;
        w_go_bin    = 1'b0;
        w_go_dec    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_go_bin    = En_AU;
                    w_go_dec    = En_DU;
                    w_state_nxt = En_AU ? DONE : DEC;
                end
            end
            DEC: begin
                if (Abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_last) begin
                        w_last      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // A start here chains back-to-back; Abort drops it.
                if (!Abort && w_start) begin
                    w_go_bin    = En_AU;
                    w_go_dec    = En_DU;
                    w_state_nxt = En_AU ? DONE : DEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_q       <= '0;
            r_m       <= '0;
            r_op      <= 1'b0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_ov_pend <= 1'b0;
            r_out     <= '0;
            r_ov      <= 1'b0;
        end else begin
            if (w_go_bin) begin
                r_out <= w_bin;
                r_ov  <= w_ov;
            end

            if (w_go_dec) begin
                r_q       <= Q;
                r_m       <= w_m_in;
                r_op      <= Op;
                r_c       <= Ci;
                r_cnt     <= '0;
                r_ov_pend <= w_ov;
            end

            if (w_step) begin
                r_q   <= w_q_nxt;
                r_m   <= {4'h0, r_m[c_width-1:4]};
                r_c   <= w_dc;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_out <= {w_dc, w_q_nxt};
                    r_ov  <= r_ov_pend;
                    r_cnt <= '0;
                end
            end

            // Abort leaves Out/OV alone but rewinds the digit counter.
            if ((r_state == DEC) && Abort) begin
                r_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Rdy = (r_state == IDLE) || (r_state == DONE);
    assign Val = (r_state == DONE);
    assign Out = r_out;
    assign OV  = r_ov;

endmodule : m65c02_add_n
`default_nettype wire

// File: tb/tb_m65c02_add_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m65c02_add_n
//  Description : Self-checking bench for m65c02_add_n (DIGITS = 4). Expected
//                values come from decimal/two's-complement integer models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m65c02_add_n;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        En_AU = 1'b0;
    logic        En_DU = 1'b0;
    logic        Op = 1'b0;
    logic [15:0] Q = '0;
    logic [15:0] R = '0;
    logic        Ci = 1'b0;
    logic        Abort = 1'b0;
    logic        Rdy;
    logic [16:0] Out;
    logic        OV;
    logic        Val;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    m65c02_add_n #(.DIGITS(4), .CW(3)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .En_AU (En_AU),
        .En_DU (En_DU),
        .Op    (Op),
        .Q     (Q),
        .R     (R),
        .Ci    (Ci),
        .Abort (Abort),
        .Rdy   (Rdy),
        .Out   (Out),
        .OV    (OV),
        .Val   (Val)
    );

    // ---------------- reference model ----------------
    function automatic int bcd2int(input logic [15:0] v);
        int n = 0;
        int p = 1;
        for (int k = 0; k < 4; k++) begin
            n = n + int'(v[4*k +: 4]) * p;
            p = p * 10;
        end
        return n;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] v = '0;
        int x = n;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    function automatic logic [16:0] model_dec(input logic [15:0] q, input logic [15:0] r,
                                              input logic op, input logic ci);
        int s;
        logic c;
        if (!op) begin
            s = bcd2int(q) + bcd2int(r) + int'(ci);
            c = (s >= 10000);
            s = s % 10000;
        end else begin
            s = bcd2int(q) - bcd2int(r) - (1 - int'(ci));
            c = (s >= 0);
            if (s < 0) s = s + 10000;
        end
        return {c, int2bcd(s)};
    endfunction

    function automatic logic [16:0] model_bin(input logic [15:0] q, input logic [15:0] r,
                                              input logic op, input logic ci);
        logic [15:0] mm = op ? ~r : r;
        return {1'b0, q} + {1'b0, mm} + 17'(ci);
    endfunction

    function automatic logic model_ov(input logic [15:0] q, input logic [15:0] r,
                                      input logic op, input logic ci);
        logic [15:0] mm = op ? ~r : r;
        int s = int'($signed(q)) + int'($signed(mm)) + int'(ci);
        return (s > 32767) || (s < -32768);
    endfunction

    // ---------------- stimulus helper ----------------
    // Entered 1 time unit after a rising edge. Returns latency in edges from
    // the start edge to the edge at which Val is first sampled high (-1 on
    // timeout), plus whether Rdy stayed low and Out held while busy.
    task automatic do_op(input logic au, input logic du, input logic op,
                         input logic [15:0] q, input logic [15:0] r, input logic ci,
                         output int lat, output logic [16:0] o, output logic ov,
                         output logic rdy_low, output logic held);
        logic [16:0] prev;
        prev    = Out;
        rdy_low = 1'b1;
        held    = 1'b1;
        En_AU = au; En_DU = du; Op = op; Q = q; R = r; Ci = ci;
        @(posedge Clk); #1;
        En_AU = 1'b0; En_DU = 1'b0;
        Q = 16'($urandom); R = 16'($urandom); Op = 1'($urandom); Ci = 1'($urandom);
        lat = 1;
        o   = 'x;
        ov  = 1'bx;
        while ((lat <= 20) && !Val) begin
            if (Rdy) rdy_low = 1'b0;
            if (Out !== prev) held = 1'b0;
            @(posedge Clk); #1;
            lat++;
        end
        if (Val) begin
            o  = Out;
            ov = OV;
        end else begin
            lat = -1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 Rst = 1'b1;
        #2;
        total++; if (Out !== 17'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", Out, 17'h0); end
        total++; if (OV !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", OV); end
        total++; if (Val !== 1'b0) begin bad++; $display("FAIL reset_val got=%b exp=0", Val); end
        total++; if (Rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", Rdy); end
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    task automatic test_dec_directed();
        int lat; logic [16:0] o; logic ov, rl, h;
        do_op(1'b0, 1'b1, 1'b0, 16'h0999, 16'h0001, 1'b0, lat, o, ov, rl, h);
        total++; if (o !== 17'h0_1000) begin bad++; $display("FAIL dec_0999p1 got=%h exp=%h", o, 17'h0_1000); end
        total++; if (lat !== 5) begin bad++; $display("FAIL dec_latency got=%0d exp=5", lat); end
        total++; if (rl !== 1'b1) begin bad++; $display("FAIL dec_rdy_busy got=%b exp=1", rl); end
        total++; if (h !== 1'b1) begin bad++; $display("FAIL dec_out_hold got=%b exp=1", h); end
        total++; if (ov !== model_ov(16'h0999, 16'h0001, 1'b0, 1'b0)) begin bad++; $display("FAIL dec_ov got=%b exp=%b", ov, model_ov(16'h0999, 16'h0001, 1'b0, 1'b0)); end

        do_op(1'b0, 1'b1, 1'b0, 16'h9999, 16'h0001, 1'b0, lat, o, ov, rl, h);
        total++; if (o !== 17'h1_0000) begin bad++; $display("FAIL dec_9999p1 got=%h exp=%h", o, 17'h1_0000); end

        do_op(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b1, lat, o, ov, rl, h);
        total++; if (o !== 17'h0_9999) begin bad++; $display("FAIL dec_0m1 got=%h exp=%h", o, 17'h0_9999); end

        do_op(1'b0, 1'b1, 1'b1, 16'h1000, 16'h0001, 1'b1, lat, o, ov, rl, h);
        total++; if (o !== 17'h1_0999) begin bad++; $display("FAIL dec_1000m1 got=%h exp=%h", o, 17'h1_0999); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [16:0] o; logic ov, rl, h;
        // Called while the previous op sits in DONE: this start lands on
        // the edge that ends DONE.
        do_op(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0, lat, o, ov, rl, h);
        total++; if (lat !== 5) begin bad++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        total++; if (o !== 17'h0_0003) begin bad++; $display("FAIL b2b_out got=%h exp=%h", o, 17'h0_0003); end
    endtask

    task automatic test_binary();
        int lat; logic [16:0] o; logic ov, rl, h;
        logic ok;
        do_op(1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, lat, o, ov, rl, h);
        total++; if (o !== 17'h0_8000) begin bad++; $display("FAIL bin_out got=%h exp=%h", o, 17'h0_8000); end
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL bin_ov got=%b exp=1", ov); end
        total++; if (lat !== 1) begin bad++; $display("FAIL bin_latency got=%0d exp=1", lat); end

        En_AU = 1'b1; En_DU = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            if ((Val !== 1'b0) || (Rdy !== 1'b1)) ok = 1'b0;
        end
        En_AU = 1'b0; En_DU = 1'b0;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL both_en_noop got=%b exp=1", ok); end
    endtask

    task automatic test_abort();
        logic [16:0] prior;
        logic ok;
        prior = Out;
        En_DU = 1'b1; Op = 1'b0; Q = 16'h1234; R = 16'h4321; Ci = 1'b0;
        @(posedge Clk); #1;            // E0
        En_DU = 1'b0;
        @(posedge Clk); #1;            // E1
        Abort = 1'b1;
        @(posedge Clk); #1;            // E2
        Abort = 1'b0;
        total++; if (Rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", Rdy); end
        total++; if (Out !== prior) begin bad++; $display("FAIL abort_out got=%h exp=%h", Out, prior); end
        ok = 1'b1;
        repeat (6) begin
            if (Val !== 1'b0) ok = 1'b0;
            @(posedge Clk); #1;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_noval got=%b exp=1", ok); end
    endtask

    task automatic test_abort_done();
        int lat; logic [16:0] o; logic ov, rl, h;
        logic ok;
        do_op(1'b0, 1'b1, 1'b0, 16'h0042, 16'h0058, 1'b0, lat, o, ov, rl, h);
        total++; if (o !== 17'h0_0100) begin bad++; $display("FAIL abdone_first got=%h exp=%h", o, 17'h0_0100); end
        Abort = 1'b1; En_DU = 1'b1; Q = 16'h1111; R = 16'h2222;
        @(posedge Clk); #1;
        Abort = 1'b0; En_DU = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            if ((Val !== 1'b0) || (Rdy !== 1'b1) || (Out !== 17'h0_0100)) ok = 1'b0;
            @(posedge Clk); #1;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_drops_start got=%b exp=1", ok); end
    endtask

    task automatic test_rst_mid();
        int lat; logic [16:0] o; logic ov, rl, h;
        logic ok;
        // Leave a non-zero Out/OV behind first.
        do_op(1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, lat, o, ov, rl, h);
        En_DU = 1'b1; Op = 1'b0; Q = 16'h5555; R = 16'h4444; Ci = 1'b0;
        @(posedge Clk); #1;            // E0
        En_DU = 1'b0;
        @(posedge Clk); #1;            // E1, mid-DEC
        #2 Rst = 1'b1;
        #1;
        total++; if (Out !== 17'h0) begin bad++; $display("FAIL rst_mid_out got=%h exp=%h", Out, 17'h0); end
        total++; if (OV !== 1'b0) begin bad++; $display("FAIL rst_mid_ov got=%b exp=0", OV); end
        total++; if (Val !== 1'b0) begin bad++; $display("FAIL rst_mid_val got=%b exp=0", Val); end
        total++; if (Rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_rdy got=%b exp=1", Rdy); end
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        ok = 1'b1;
        repeat (5) begin
            if ((Val !== 1'b0) || (Rdy !== 1'b1)) ok = 1'b0;
            @(posedge Clk); #1;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b exp=1", ok); end
        do_op(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005, 1'b0, lat, o, ov, rl, h);
        total++; if ((o !== 17'h0_0010) || (lat !== 5)) begin bad++; $display("FAIL rst_mid_after got=%h/%0d exp=%h/5", o, lat, 17'h0_0010); end
    endtask

    task automatic test_random();
        int lat; logic [16:0] o; logic ov, rl, h;
        logic au, op, ci;
        logic [15:0] q, r;
        logic [16:0] exp_o;
        logic exp_ov;
        int exp_lat;
        for (int i = 0; i < 40; i++) begin
            au = 1'($urandom);
            op = 1'($urandom);
            ci = 1'($urandom);
            if (au) begin
                q = 16'($urandom);
                r = 16'($urandom);
                exp_o   = model_bin(q, r, op, ci);
                exp_lat = 1;
            end else begin
                q = int2bcd(int'($urandom_range(0, 9999)));
                r = int2bcd(int'($urandom_range(0, 9999)));
                exp_o   = model_dec(q, r, op, ci);
                exp_lat = 5;
            end
            exp_ov = model_ov(q, r, op, ci);
            repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            do_op(au, !au, op, q, r, ci, lat, o, ov, rl, h);
            total++; if (o !== exp_o) begin bad++; $display("FAIL rnd_out[%0d] au=%b op=%b q=%h r=%h ci=%b got=%h exp=%h", i, au, op, q, r, ci, o, exp_o); end
            total++; if (ov !== exp_ov) begin bad++; $display("FAIL rnd_ov[%0d] got=%b exp=%b", i, ov, exp_ov); end
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge Clk); #1;
        test_dec_directed();
        test_back_to_back();
        test_binary();
        test_abort();
        test_abort_done();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_m65c02_add_n
`default_nettype wire

// File: doc/m65c02_add_n.md
Name: m65c02_add_n

Overview:
- Parametrised successor to the 8-bit M65C02 binary/decimal adder, used by the 16-bit-capable ALU (M65C02A extended ops).
- Binary add/subtract completes in one registered cycle.
- Decimal (BCD) add/subtract runs digit-serially, one nibble per clock, LSN first, with a digit-carry register. Width scales without growing the adjust logic.
- Accepts one operation at a time; a Rdy/Val pair handshakes with the ALU sequencer.

Parameters:
- DIGITS, 4, number of 4-bit digits; operand width W = 4*DIGITS (legal 2..8).
- CW, 3, width of the digit counter; must satisfy 2^CW > DIGITS.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- En_AU  in  1  start binary operation.
- En_DU  in  1  start decimal operation.
- Op  in  1  0 = add, 1 = subtract (right operand inverted).
- Q  in  W  left operand.
- R  in  W  right operand.
- Ci  in  1  carry in (subtract: 1 = no borrow).
- Abort  in  1  synchronous cancel of an in-flight operation.
- Rdy  out  1  block idle, or in Val cycle; start accepted.
- Out  out  W+1  {carry-out, result}.
- OV  out  1  two's-complement overflow.
- Val  out  1  one-cycle result-valid pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state IDLE, Out=0, OV=0, Val=0, Rdy=1, digit counter=0, digit carry=0.
- Start rule: a start is sampled only when Rdy=1 and En_AU^En_DU=1.
  - En_AU=En_DU=1 or both 0: no operation, no state change.
  - Q, R, Op, Ci are latched at the start edge (E0).
  - M = Op ? ~R : R.
- States: IDLE, DEC, DONE.
- Binary (En_AU): at E0, compute {C,S} = Q + M + Ci in full width.
  - Register Out={C,S} and OV = C[W-1]^C[W-2] (carry into MSB xor carry out).
  - Val=1 in the following cycle (latency 1). State goes IDLE->DONE->IDLE.
- Decimal (En_DU): E0 latches operands; state -> DEC; counter=0; digit carry = Ci.
  - Each edge in DEC processes digit k = counter: t = Q_k + M_k + c (5-bit).
  - Add: if t>9 then digit = t+6 (mod 16), c=1; else digit = t, c=0.
  - Subtract: if t<16 then digit = t+0xA (mod 16), c=0; else digit = t-16, c=1.
  - Digit written into result shift register; counter increments.
  - After the edge processing digit DIGITS-1: state -> DONE, Out = {c, result}, OV = binary overflow of Q+M+Ci (computed and latched at E0), Val=1.
  - Latency DIGITS+1 edges from start to Val.
- DONE: Val=1 for exactly one cycle; Rdy=1 in this cycle, so a start on the edge ending DONE is accepted (back-to-back, no bubble). Otherwise return to IDLE.
- Rdy=0 in DEC and in the binary in-flight cycle; Rdy=1 in IDLE and DONE.
- Out and OV hold their last value until the next Val; they do not change during DEC.
- Abort in DEC: next state IDLE, no Val, Out/OV unchanged, counter cleared. Abort in IDLE/DONE has no effect. Abort with a simultaneous start in DONE: Abort wins and the start is dropped.
- Non-BCD input digits (>9) are processed by the same rules; the result is deterministic but not meaningful.
- Digit arithmetic wraps mod 16; the final carry appears only in Out[W].

Decomposition:
- Shared package m65c02_add_pkg:
  - state enum (IDLE, DEC, DONE);
  - adjust constants ADJ_ADD=4'h6, ADJ_SUB=4'hA;
  - digit limit 4'd9;
  - Op encodings OP_ADD=0, OP_SUB=1.
- One sub-module m65c02_bcd_digit: combinational nibble cell taking (q, m, c_in, op) and producing (digit, c_out). Instantiated once and time-multiplexed by the counter.

Test Plan (DIGITS=4):
- Decimal add, Q=16'h0999, R=16'h0001, Ci=0 -> Val at edge E0+5, Out=17'h0_1000, Rdy=0 for E1..E4.
- Decimal add, Q=16'h9999, R=16'h0001, Ci=0 -> Out=17'h1_0000 (carry set). Then decimal sub, Q=16'h0000, R=16'h0001, Ci=1 -> Out=17'h0_9999 (borrow).
- Decimal sub, Q=16'h1000, R=16'h0001, Ci=1 -> Out=17'h1_0999. Issue the next start in the DONE cycle; its Val arrives exactly 5 edges later.
- Binary add, Q=16'h7FFF, R=16'h0001, Ci=0 -> Val one cycle later, Out=17'h0_8000, OV=1. En_AU=En_DU=1 -> no Val, Rdy stays 1.
- Abort asserted at E2 of a decimal op -> no Val, Rdy=1 next cycle, Out holds the prior value. Rst pulsed mid-DEC -> Out=0, OV=0, Val=0, Rdy=1 immediately (asynchronous).
